stopwatch_up: RTL and testbench
===============================

Name: stopwatch_up

Overview:
- Count-up stopwatch, MM:SS from 00:00 to 59:59; the counterpart of the count-down game timer.
- Driven by start/stop/clear pulses from the debounced button front-end.
- Multiplexes four BCD digits onto the shared 7-segment bus (anode enables plus common segment lines).
- Flags rollover past 59:59 so game logic can end a round.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per counted second (100 MHz to 1 Hz); sims use 10.
- SCAN_DIV, 100_000: clk cycles each digit is displayed before advancing; sims use 4.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle pulse, synchronous to clk: begin/resume counting
- stop  in  1  single-cycle pulse: pause counting
- clear  in  1  single-cycle pulse: return to 00:00, stopped
- running  out  1  high while in RUN
- overflow  out  1  sticky; set on 59:59 to 00:00 rollover
- seg_en  out  4  one-hot digit enable, active-high; bit0 = seconds ones, bit3 = minutes tens
- seg_out  out  8  segments {a,b,c,d,e,f,g,dp}, active-high; digit 0 = 8'b1111_1100

Behaviour:
- Reset values: all digits 0, state IDLE, prescaler 0, scan counter 0, digit index 0, running=0, overflow=0, seg_en=4'b0001, seg_out=8'b1111_1100.
- Single clock domain only; no derived or divided clocks. Scan and second ticks are clk-enable strobes.
- States:
  - IDLE: digits 00:00, stopped.
  - RUN: counting.
  - PAUSE: digits and prescaler held.
- Transitions:
  - IDLE+start -> RUN
  - RUN+stop -> PAUSE
  - PAUSE+start -> RUN
  - any state + clear -> IDLE
  - start in RUN, or stop in IDLE/PAUSE, is ignored.
- Same-cycle priority: clear > stop > start.
  - start+stop in IDLE stays IDLE.
  - start+stop in PAUSE stays PAUSE.
  - start+stop in RUN goes to PAUSE.
- Prescaler: counts 0..TICK_DIV-1, advancing only in RUN.
  - Wraps to 0 and emits a one-cycle sec_tick when it equals TICK_DIV-1.
  - Held in PAUSE, so resume keeps the fractional second.
  - Zeroed by clear.
- First second timing: after start from IDLE, the first increment occurs exactly TICK_DIV cycles after the cycle in which start is sampled.
- Digit increment on sec_tick, BCD ripple:
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
  - min_tens 5 -> 0 wraps to 00:00 and sets overflow.
- Overflow rules: counting continues after wrap. overflow clears only on clear or rst. A clear in the same cycle as the wrap tick wins: result is 00:00 with overflow=0.
- running = (state==RUN). It is registered and reflects the state in the cycle after the pulse.
- Scan counter: free-running 0..SCAN_DIV-1 in all states. At wrap, digit index advances 0, 1, 2, 3, 0.
- seg_en and seg_out are registered together from the current index and digit value, so they are never skewed.
- Segment encodings (digit 0-9): 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 F6 (hex).
- dp (bit0) is forced to 1 on digit index 2 to act as the MM.SS separator. So digit 2 showing 0 outputs 8'b1111_1101.
- Non-BCD digit values are unreachable; the decoder default is 8'b0000_0001.
- Reset mid-count: immediate return to reset values, independent of clk.

Decomposition:
- Shared package seg7_pkg:
  - 8-bit segment constants SEG_0..SEG_9 and SEG_BLANK
  - state enum {IDLE, RUN, PAUSE}
  - the bcd_to_seg function
- One sub-module, seg7_scan4: scan counter, digit index, and registered seg_en/seg_out.
  - Takes four 4-bit BCD digits and a dp mask; parameterised by SCAN_DIV.
- Timer FSM, prescaler and BCD counters stay in stopwatch_up.

Test Plan (TICK_DIV=10, SCAN_DIV=4):
- Reset: assert rst mid-cycle -> seg_en=0001, seg_out=FC, running=0, overflow=0 immediately; hold 20 cycles -> digits stay 00:00.
- Start then count: start pulse, run 10*75 cycles -> digits 01:15 (digit3=0, digit2=1, digit1=1, digit0=5); digit2 shows 8'b0110_0001.
- Pause/resume: start, wait 15 cycles (1 s and 5 cycles), stop, wait 100, start, wait 5 -> second digit rolls to 2 exactly 5 cycles after resume; during pause digits hold 00:01.
- Priority: in RUN, pulse start+stop together -> PAUSE, running=0. In PAUSE, pulse clear+start -> IDLE, 00:00.
- Overflow: run 3600 seconds -> display 00:00, overflow=1, still running; clear -> overflow=0, running=0.
- Scan: in IDLE, observe seg_en 0001, 0010, 0100, 1000, 0001 changing every 4 cycles; seg_out=FC except FD while seg_en=0100.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, timer state encoding and BCD decoder.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  // dp only: a visible marker should an impossible digit ever appear
  localparam logic [7:0] SEG_BLANK = 8'h01;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = SEG_0;
      4'd1:    bcd_to_seg = SEG_1;
      4'd2:    bcd_to_seg = SEG_2;
      4'd3:    bcd_to_seg = SEG_3;
      4'd4:    bcd_to_seg = SEG_4;
      4'd5:    bcd_to_seg = SEG_5;
      4'd6:    bcd_to_seg = SEG_6;
      4'd7:    bcd_to_seg = SEG_7;
      4'd8:    bcd_to_seg = SEG_8;
      4'd9:    bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_up_if.sv
// Button pulses in, status flags and multiplexed 7-segment bus out.
interface stopwatch_up_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       running;
  logic       overflow;
  logic [3:0] seg_en;
  logic [7:0] seg_out;

  modport master (output start, stop, clear,
                  input  running, overflow, seg_en, seg_out);
  modport slave  (input  start, stop, clear,
                  output running, overflow, seg_en, seg_out);
endinterface

// File: rtl/seg7_scan4.sv
// Four-digit 7-segment scanner; enable and segments share one register stage.
module seg7_scan4
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0][3:0] i_digits,
  input  logic [3:0]      i_dp,
  output logic [3:0]      o_seg_en,
  output logic [7:0]      o_seg_out
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0] r_scan;
  logic [1:0]    r_idx;
  logic [3:0]    r_seg_en;
  logic [7:0]    r_seg_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan    <= '0;
      r_idx     <= '0;
      r_seg_en  <= 4'b0001;
      r_seg_out <= SEG_0;
    end else begin
      if (r_scan == SCAN_LAST) begin
        r_scan <= '0;
        r_idx  <= r_idx + 2'd1;
      end else begin
        r_scan <= r_scan + SW'(1);
      end
      r_seg_en  <= 4'b0001 << r_idx;
      r_seg_out <= bcd_to_seg(i_digits[r_idx]) | {7'b0, i_dp[r_idx]};
    end
  end

  assign o_seg_en  = r_seg_en;
  assign o_seg_out = r_seg_out;

endmodule

// File: rtl/stopwatch_up.sv
// MM:SS count-up stopwatch with sticky rollover flag and scanned 7-seg display.
module stopwatch_up
  import seg7_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_up_if.slave  sw
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  sw_state_t       r_state;
  logic [PW-1:0]   r_presc;
  logic [3:0][3:0] r_d;       // {min_tens, min_ones, sec_tens, sec_ones}
  logic            r_ovf;
  logic            r_running;
  logic            w_tick;

  assign w_tick = (r_state == RUN) && (r_presc == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_d       <= '0;
      r_ovf     <= 1'b0;
      r_running <= 1'b0;
    end else if (sw.clear) begin
      // clear beats a coincident wrap tick, so overflow stays low
      r_state   <= IDLE;
      r_presc   <= '0;
      r_d       <= '0;
      r_ovf     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      if (r_state == RUN)
        r_presc <= w_tick ? '0 : r_presc + PW'(1);

      if (w_tick) begin
        if (r_d[0] == 4'd9) begin
          r_d[0] <= 4'd0;
          if (r_d[1] == 4'd5) begin
            r_d[1] <= 4'd0;
            if (r_d[2] == 4'd9) begin
              r_d[2] <= 4'd0;
              if (r_d[3] == 4'd5) begin
                r_d[3] <= 4'd0;
                r_ovf  <= 1'b1;
              end else begin
                r_d[3] <= r_d[3] + 4'd1;
              end
            end else begin
              r_d[2] <= r_d[2] + 4'd1;
            end
          end else begin
            r_d[1] <= r_d[1] + 4'd1;
          end
        end else begin
          r_d[0] <= r_d[0] + 4'd1;
        end
      end

      case (r_state)
        RUN: if (sw.stop) begin
          r_state   <= PAUSE;
          r_running <= 1'b0;
        end
        IDLE, PAUSE: if (sw.start && !sw.stop) begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  seg7_scan4 #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk       (clk),
    .rst       (rst),
    .i_digits  (r_d),
    .i_dp      (4'b0100),
    .o_seg_en  (sw.seg_en),
    .o_seg_out (sw.seg_out)
  );

  assign sw.running  = r_running;
  assign sw.overflow = r_ovf;

endmodule

// File: tb/tb_stopwatch_up.sv
// Randomized and directed bench against a seconds-count reference model.
module tb_stopwatch_up;

  localparam int TD = 10;
  localparam int SD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stopwatch_up_if sw_if();

  stopwatch_up #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] enc [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                           8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  // model: elapsed seconds 0..3599, cycles into current second, cycles since reset
  int         m_secs, m_frac, m_cyc, m_st;
  bit         m_ovf;
  logic [3:0] m_en;
  logic [7:0] m_seg;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h secs=%0d t=%0t", tag, got, exp, m_secs, $time);
    end
  endtask

  function automatic logic [7:0] disp(int idx);
    int d;
    case (idx)
      0:       d = m_secs % 10;
      1:       d = (m_secs % 60) / 10;
      2:       d = (m_secs / 60) % 10;
      default: d = m_secs / 600;
    endcase
    return enc[d] | ((idx == 2) ? 8'h01 : 8'h00);
  endfunction

  task automatic mreset();
    m_secs = 0; m_frac = 0; m_cyc = 0; m_st = M_IDLE; m_ovf = 0;
    m_en = 4'b0001; m_seg = 8'hFC;
  endtask

  task automatic model(bit s, bit p, bit c);
    int idx;
    idx   = (m_cyc / SD) % 4;
    m_en  = 4'b0001 << idx;
    m_seg = disp(idx);
    m_cyc++;
    if (c) begin
      m_secs = 0; m_frac = 0; m_ovf = 0; m_st = M_IDLE;
    end else begin
      if (m_st == M_RUN) begin
        m_frac++;
        if (m_frac == TD) begin
          m_frac = 0;
          m_secs++;
          if (m_secs == 3600) begin
            m_secs = 0;
            m_ovf  = 1;
          end
        end
      end
      if (p) begin
        if (m_st == M_RUN) m_st = M_PAUSE;
      end else if (s) begin
        if (m_st != M_RUN) m_st = M_RUN;
      end
    end
  endtask

  task automatic check_outs();
    chk("running",  32'(sw_if.running),  32'(m_st == M_RUN));
    chk("overflow", 32'(sw_if.overflow), 32'(m_ovf));
    chk("seg_en",   32'(sw_if.seg_en),   32'(m_en));
    chk("seg_out",  32'(sw_if.seg_out),  32'(m_seg));
  endtask

  // called at a negedge; returns at the next negedge with outputs checked
  task automatic cyc(bit s, bit p, bit c);
    sw_if.start = s; sw_if.stop = p; sw_if.clear = c;
    @(posedge clk);
    model(s, p, c);
    @(negedge clk);
    sw_if.start = 0; sw_if.stop = 0; sw_if.clear = 0;
    check_outs();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    mreset();
    #1 check_outs();
    repeat (20) begin
      @(negedge clk);
      check_outs();
    end
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    sw_if.start = 0; sw_if.stop = 0; sw_if.clear = 0;
    mreset();
    @(negedge clk);
    do_reset();

    // scan in IDLE
    repeat (24) cyc(0, 0, 0);

    // start then count to 01:15
    cyc(1, 0, 0);
    repeat (10 * 75) cyc(0, 0, 0);
    chk("secs_0115", 32'(m_secs), 32'd75);
    repeat (16) cyc(0, 0, 0);

    // reset mid-count
    do_reset();

    // pause / resume keeps fractional second
    cyc(1, 0, 0);
    repeat (15) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (100) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (25) cyc(0, 0, 0);

    // priority: start+stop in RUN pauses; clear+start in PAUSE idles
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    repeat (7) cyc(0, 0, 0);
    cyc(1, 1, 0);
    repeat (30) cyc(0, 0, 0);
    cyc(1, 1, 0);
    repeat (5) cyc(0, 0, 0);
    cyc(1, 0, 1);
    repeat (12) cyc(0, 0, 0);
    cyc(1, 1, 0);
    repeat (8) cyc(0, 0, 0);

    // full hour: wrap to 00:00 with overflow, still running, then clear
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    repeat (3600 * TD) cyc(0, 0, 0);
    repeat (30) cyc(0, 0, 0);
    cyc(0, 0, 1);
    repeat (4) cyc(0, 0, 0);

    // clear coincident with the wrap tick wins
    cyc(1, 0, 0);
    guard = 0;
    while (!(m_secs == 3599 && m_frac == TD - 1) && guard < 40000) begin
      cyc(0, 0, 0);
      guard++;
    end
    chk("wrap_reach", 32'(guard < 40000), 32'd1);
    cyc(0, 0, 1);
    repeat (16) cyc(0, 0, 0);

    // random pulses
    repeat (4000) begin
      cyc($urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
